// File: rtl/ppu_pool_pkg.sv
// ppu_pool_pkg
// Shared definitions for the PPU max-pool datapath: the window sequencer
// state encoding and the fixed 2x2 / stride-2 pooling geometry.
package ppu_pool_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } pool_seq_state_e;

  localparam int POOL_WIN_ELEMS = 4;
  localparam int POOL_STRIDE    = 2;

endpackage

// File: rtl/maxpool_addr_gen.sv
// maxpool_addr_gen
// Walks 2x2 / stride-2 windows row-major over a W x H byte image and produces
// the buffer address of the current element. The row base advances by 2W per
// window row, so no multiplier is needed. Arithmetic wraps modulo 2^ADDR_W.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture base_addr/img_width/img_height, rewind to window 0
//   step         current element was issued; advance to the next element
//   base_addr    address of pixel (0,0)
//   img_width    columns W
//   img_height   rows H
//   last_elem    current element is the 4th of its window
//   last_win     current window is the final one of the job
//   addr         address of the current element
module maxpool_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  output logic              last_elem,
  output logic              last_win,
  output logic [ADDR_W-1:0] addr
);
  import ppu_pool_pkg::*;

  localparam int ELEM_W = $clog2(POOL_WIN_ELEMS);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] w_ext;
  logic [7:0]        col2;    // 2c: column of the window's left pixel
  logic [7:0]        row2;    // 2r: row of the window's top pixel
  logic [7:0]        w_reg;
  logic [7:0]        h_reg;
  logic [ELEM_W-1:0] elem;
  logic              last_col;
  logic              last_row;

  assign w_ext = ADDR_W'(w_reg);

  // A window fits only if its right/bottom pixel (2c+1 / 2r+1) is inside the
  // image; the last one is where the next window would not, i.e. 2c+3 >= W.
  // This drops an odd trailing column/row without halving W or H.
  assign last_col = ({1'b0, col2} + 9'(2 * POOL_STRIDE - 1)) >= {1'b0, w_reg};
  assign last_row = ({1'b0, row2} + 9'(2 * POOL_STRIDE - 1)) >= {1'b0, h_reg};

  assign last_elem = (elem == ELEM_W'(POOL_WIN_ELEMS - 1));
  assign last_win  = last_col && last_row;

  // Element order A, A+1, A+W, A+W+1: bit 1 selects the lower row, bit 0 the
  // right column.
  assign addr = row_base + ADDR_W'(col2) + (elem[1] ? w_ext : '0) + ADDR_W'(elem[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      col2     <= '0;
      row2     <= '0;
      w_reg    <= '0;
      h_reg    <= '0;
      elem     <= '0;
    end else if (load) begin
      row_base <= base_addr;
      col2     <= '0;
      row2     <= '0;
      w_reg    <= img_width;
      h_reg    <= img_height;
      elem     <= '0;
    end else if (step) begin
      elem <= elem + ELEM_W'(1);
      if (last_elem) begin
        if (last_col) begin
          col2     <= '0;
          row2     <= row2 + 8'(POOL_STRIDE);
          row_base <= row_base + w_ext + w_ext;
        end else begin
          col2 <= col2 + 8'(POOL_STRIDE);
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_window_sequencer.sv
// maxpool_window_sequencer
// Streams 2x2 / stride-2 max-pool windows from the PPU input buffer into the
// Qint8 max-pool comparator: one buffer read per cycle, each returned byte
// forwarded with an enable, a single comparator clear per job and a marker
// on the last element of every window.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         job request, sampled in IDLE only
//   base_addr     address of pixel (0,0), captured at start
//   img_width     columns W, captured at start
//   img_height    rows H, captured at start
//   hold          pauses issuing reads while in READ
//   rd_en/rd_addr buffer read strobe and address
//   rd_data       buffer data, valid the cycle after rd_en
//   pool_init     one-cycle comparator clear at job start
//   pool_enable   pool_data valid
//   pool_data     element to the comparator
//   pool_last     4th element of a window (with pool_enable)
//   busy          job in progress (INIT, READ, DRAIN)
//   done          one-cycle completion pulse
module maxpool_window_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              pool_init,
  output logic              pool_enable,
  output logic [7:0]        pool_data,
  output logic              pool_last,
  output logic              busy,
  output logic              done
);
  import ppu_pool_pkg::*;

  pool_seq_state_e   state;
  logic              load;
  logic              vld_p0;
  logic              vld_p1;
  logic              last_p1;
  logic              last_elem;
  logic              last_win;
  logic [ADDR_W-1:0] gen_addr;

  assign load = (state == IDLE) && start;

  maxpool_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (vld_p0),
    .base_addr (base_addr),
    .img_width (img_width),
    .img_height(img_height),
    .last_elem (last_elem),
    .last_win  (last_win),
    .addr      (gen_addr)
  );

  // Stage p0: issue. hold acts in the same cycle so a held cycle never reads.
  assign vld_p0  = (state == READ) && !hold;
  assign rd_en   = vld_p0;
  assign rd_addr = vld_p0 ? gen_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pool_init <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (img_width < 8'd2 || img_height < 8'd2) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= INIT;
              pool_init <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        INIT: begin
          state     <= READ;
          pool_init <= 1'b0;
        end
        READ: begin
          if (vld_p0 && last_elem && last_win) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          pool_init <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: deliver. rd_data arrives now, aligned with the delayed strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_elem;
    end
  end

  assign pool_enable = vld_p1;
  assign pool_last   = last_p1;
  assign pool_data   = vld_p1 ? rd_data : '0;

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
module tb_maxpool_window_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  img_width;
  logic [7:0]  img_height;
  logic        hold;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        pool_init;
  logic        pool_enable;
  logic [7:0]  pool_data;
  logic        pool_last;
  logic        busy;
  logic        done;

  maxpool_window_sequencer #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .img_width  (img_width),
    .img_height (img_height),
    .hold       (hold),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pool_init  (pool_init),
    .pool_enable(pool_enable),
    .pool_data  (pool_data),
    .pool_last  (pool_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: pixel value is its offset from the job's base address.
  logic [15:0] mem_base = 16'h0000;
  always @(posedge clk) rd_data <= 8'(rd_addr - mem_base);

  int total = 0;
  int bad   = 0;
  int t0    = 0;

  logic [15:0] exp_addr_q[$];
  logic [8:0]  exp_el_q[$];   // {last, data}

  task automatic push_job(input logic [15:0] b, input int w, input int h);
    int idx;
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        for (int e = 0; e < 4; e++) begin
          idx = (2 * r + e / 2) * w + 2 * c + e % 2;
          exp_addr_q.push_back(16'(32'(b) + idx));
          exp_el_q.push_back({(e == 3), 8'(idx)});
        end
  endtask

  // Called at #1 after a posedge with the DUT idle; returns #1 after the
  // accepting edge t, with t0 set so that cyc - t0 == 1 in cycle t+1.
  task automatic start_job(input logic [15:0] b, input int w, input int h);
    exp_addr_q.delete();
    exp_el_q.delete();
    push_job(b, w, h);
    mem_base   = b;
    base_addr  = b;
    img_width  = 8'(w);
    img_height = 8'(h);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = 16'($urandom);
    img_width  = 8'($urandom);
    img_height = 8'($urandom);
    t0 = cyc - 1;
  endtask

  task automatic run_job(input string name, input int done_at, input bit degen,
                         input int hold_from, input int hold_len, input int restart_at);
    int          rel;
    bit          got_done = 1'b0;
    int          init_cnt = 0;
    logic        exp_busy;
    logic [15:0] ea;
    logic [8:0]  ee;
    for (int k = 0; k < done_at + 40 && !got_done; k++) begin
      rel  = cyc - t0;
      hold = (rel >= hold_from && rel < hold_from + hold_len);
      if (rel == restart_at) begin
        start      = 1'b1;
        base_addr  = 16'h7777;
        img_width  = 8'd6;
        img_height = 8'd6;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_busy = !degen && (rel < done_at);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL %s busy rel=%0d: got %b want %b", name, rel, busy, exp_busy);
      end
      if (hold) begin
        total++;
        if (rd_en !== 1'b0) begin
          bad++;
          $display("FAIL %s rd_en under hold rel=%0d: got %b want 0", name, rel, rd_en);
        end
      end
      if (pool_init === 1'b1) begin
        init_cnt++;
        total++;
        if (rel != 1) begin
          bad++;
          $display("FAIL %s pool_init timing: got rel=%0d want 1", name, rel);
        end
      end
      if (rd_en === 1'b1) begin
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra read rel=%0d: got addr %h want no read", name, rel, rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (rd_addr !== ea) begin
            bad++;
            $display("FAIL %s read addr rel=%0d: got %h want %h", name, rel, rd_addr, ea);
          end
        end
      end
      if (pool_enable === 1'b1) begin
        total++;
        if (exp_el_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra element rel=%0d: got %h want none", name, rel, pool_data);
        end else begin
          ee = exp_el_q.pop_front();
          if ({pool_last, pool_data} !== ee) begin
            bad++;
            $display("FAIL %s element rel=%0d: got last=%b data=%0d want last=%b data=%0d",
                     name, rel, pool_last, pool_data, ee[8], ee[7:0]);
          end
        end
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        total++;
        if (rel != done_at) begin
          bad++;
          $display("FAIL %s done timing: got rel=%0d want %0d", name, rel, done_at);
        end
      end
      @(posedge clk);
      #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL %s timeout: got no done want done at rel=%0d", name, done_at);
    end
    total++;
    if (exp_addr_q.size() != 0 || exp_el_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: got %0d reads %0d elements missing want 0 0",
               name, exp_addr_q.size(), exp_el_q.size());
    end
    total++;
    if (init_cnt != (degen ? 0 : 1)) begin
      bad++;
      $display("FAIL %s pool_init count: got %0d want %0d", name, init_cnt, degen ? 0 : 1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({done, rd_en, pool_enable, busy, pool_init} !== 5'b0) begin
        bad++;
        $display("FAIL %s idle after done: got done=%b rd_en=%b en=%b busy=%b init=%b want all 0",
                 name, done, rd_en, pool_enable, busy, pool_init);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    start      = 1'b0;
    hold       = 1'b0;
    base_addr  = 16'h0;
    img_width  = 8'h0;
    img_height = 8'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rd_en, rd_addr, pool_init, pool_enable, pool_data, pool_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got rd_en=%b addr=%h init=%b en=%b data=%h last=%b busy=%b done=%b want all 0",
               rd_en, rd_addr, pool_init, pool_enable, pool_data, pool_last, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_4x4;
    start_job(16'h0100, 4, 4);
    run_job("4x4", 19, 1'b0, -1, 0, -1);
  endtask

  task automatic test_odd_5x3;
    start_job(16'h0200, 5, 3);
    run_job("odd5x3", 11, 1'b0, -1, 0, -1);
  endtask

  task automatic test_hold;
    start_job(16'h0040, 2, 2);
    run_job("hold", 10, 1'b0, 4, 3, -1);
  endtask

  task automatic test_degenerate;
    start_job(16'h0500, 1, 8);
    run_job("degen", 1, 1'b1, -1, 0, -1);
  endtask

  task automatic test_start_while_busy;
    start_job(16'h0010, 4, 2);
    run_job("restart", 11, 1'b0, -1, 0, 5);
  endtask

  task automatic test_mid_reset;
    start_job(16'h0100, 4, 4);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rd_en, rd_addr, pool_init, pool_enable, pool_data, pool_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL midreset outputs: got rd_en=%b addr=%h init=%b en=%b data=%h last=%b busy=%b done=%b want all 0",
               rd_en, rd_addr, pool_init, pool_enable, pool_data, pool_last, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_en, pool_enable, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL midreset release: got rd_en=%b en=%b busy=%b done=%b want all 0",
               rd_en, pool_enable, busy, done);
    end
    @(posedge clk);
    #1;
    start_job(16'h0300, 2, 4);
    run_job("after_reset", 11, 1'b0, -1, 0, -1);
  endtask

  task automatic test_wrap;
    start_job(16'hFFFF, 2, 2);
    run_job("wrap", 7, 1'b0, -1, 0, -1);
  endtask

  task automatic test_back_to_back;
    start_job(16'h0020, 6, 4);
    run_job("b2b_a", 27, 1'b0, -1, 0, -1);
    start_job(16'h0080, 2, 6);
    run_job("b2b_b", 15, 1'b0, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_4x4();
    test_odd_5x3();
    test_hold();
    test_degenerate();
    test_start_while_busy();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
